fetch_queue: RTL

Instruction buffer between the fetch stage and decode. Each cycle it captures the fetched instruction together with its pc, pcPlus4 and err. It hands entries to decode in order over a valid/ready handshake. Back-pressure from decode is absorbed here, so fetch sees only `in_ready` and never a direct decode stall. A branch, jump or interrupt redirect flushes every buffered wrong-path entry in one cycle.

---
 rtl/fetch_queue.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction buffer between fetch and decode with one-cycle flush
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_pcPlus4,
    input  logic                         in_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_pcPlus4,
    output logic                         out_err,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [96:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic [96:0]   head;

    assign in_ready  = (count_q < CW'(DEPTH));
    // Gating with flush keeps decode from consuming a wrong-path entry in the redirect cycle.
    assign out_valid = (count_q != '0) && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    assign head        = mem_q[rd_ptr_q];
    assign out_instr   = head[96:65];
    assign out_pc      = head[64:33];
    assign out_pcPlus4 = head[32:1];
    assign out_err     = head[0];
    assign count       = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage survives a flush; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= {in_instr, in_pc, in_pcPlus4, in_err};
        end
    end

endmodule
